// File: rtl/multi_ch_readout_if.sv
// Bus between the readout sequencer, the per-channel sample buffers and the event FIFO.
// The sequencer takes the master side; the buffers/FIFO environment takes the slave side.
interface multi_ch_readout_if #(
    parameter int NCH     = 4,
    parameter int CH_BITS = 2,
    parameter int DW      = 16
);
    logic [NCH-1:0]     DAVAIL;
    logic               FIFO_FULL;
    logic [DW-1:0]      CH_DATA;
    logic [CH_BITS-1:0] CHSEL;
    logic               CH_RD;
    logic               WR_EN;
    logic [DW-1:0]      WR_DATA;
    logic               BUSY;

    modport master (
        input  DAVAIL, FIFO_FULL, CH_DATA,
        output CHSEL, CH_RD, WR_EN, WR_DATA, BUSY
    );

    modport slave (
        output DAVAIL, FIFO_FULL, CH_DATA,
        input  CHSEL, CH_RD, WR_EN, WR_DATA, BUSY
    );
endinterface

// File: rtl/multi_ch_readout.sv
// Multi-channel event readout sequencer: snapshots DAVAIL and writes one framed event
// (header, per-channel header + NSAMP samples, trailer) into the event FIFO.
module multi_ch_readout #(
    parameter int       NCH     = 4,
    parameter int       CH_BITS = 2,
    parameter int       NSAMP   = 16,
    parameter int       DW      = 16,
    parameter bit [3:0] HDR_TAG = 4'hA,
    parameter bit [3:0] CH_TAG  = 4'hC,
    parameter bit [3:0] TRL_TAG = 4'hE
) (
    input  logic                 CLK,
    input  logic                 RST,
    multi_ch_readout_if.master   bus
);

    localparam int SW = $clog2(NSAMP + 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE_HEADER,
        CH_SELECT,
        READOUT,
        WRITE_TRAILER
    } state_t;

    state_t         state;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] mask_left;
    logic [15:0]    evt_cnt;
    logic [15:0]    wcnt;
    logic [SW-1:0]  scnt;
    logic           adv;
    logic           last_samp;

    function automatic logic [CH_BITS-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CH_BITS'(i);
        end
    endfunction

    function automatic logic [DW-1:0] hdr_word(input logic [NCH-1:0] m, input logic [7:0] evt);
        return {HDR_TAG, (DW-4)'({m, evt})};
    endfunction

    function automatic logic [DW-1:0] ch_word(input logic [CH_BITS-1:0] idx);
        return {CH_TAG, (DW-4)'(idx)};
    endfunction

    function automatic logic [DW-1:0] trl_word(input logic [11:0] cnt);
        return {TRL_TAG, (DW-4)'(cnt)};
    endfunction

    assign adv       = !bus.FIFO_FULL;
    assign last_samp = (scnt == SW'(NSAMP - 1));
    // Channels still pending once the currently selected one is finished.
    assign mask_left = mask & ~(NCH'(1) << bus.CHSEL);

    // Sample pop is combinational so the buffer output is consumed in the same cycle it is issued.
    assign bus.CH_RD = (state == READOUT) && adv && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bus.CHSEL   <= '0;
            bus.WR_EN   <= 1'b0;
            bus.WR_DATA <= '0;
            bus.BUSY    <= 1'b0;
            evt_cnt     <= '0;
            wcnt        <= '0;
            mask        <= '0;
            scnt        <= '0;
        end else begin
            bus.WR_EN <= 1'b0;
            case (state)
                IDLE: begin
                    // BUSY stays high through the cycle the trailer lands, and across back-to-back events.
                    bus.BUSY <= |bus.DAVAIL;
                    if (|bus.DAVAIL) begin
                        mask  <= bus.DAVAIL;
                        wcnt  <= '0;
                        state <= WRITE_HEADER;
                    end
                end
                WRITE_HEADER: begin
                    if (adv) begin
                        bus.WR_EN   <= 1'b1;
                        bus.WR_DATA <= hdr_word(mask, evt_cnt[7:0]);
                        wcnt        <= wcnt + 16'd1;
                        state       <= CH_SELECT;
                    end
                end
                CH_SELECT: begin
                    if (adv) begin
                        bus.CHSEL   <= lowest_set(mask);
                        bus.WR_EN   <= 1'b1;
                        bus.WR_DATA <= ch_word(lowest_set(mask));
                        wcnt        <= wcnt + 16'd1;
                        scnt        <= '0;
                        state       <= READOUT;
                    end
                end
                READOUT: begin
                    if (adv) begin
                        bus.WR_EN   <= 1'b1;
                        bus.WR_DATA <= bus.CH_DATA;
                        wcnt        <= wcnt + 16'd1;
                        scnt        <= scnt + SW'(1);
                        if (last_samp) begin
                            mask  <= mask_left;
                            state <= (|mask_left) ? CH_SELECT : WRITE_TRAILER;
                        end
                    end
                end
                WRITE_TRAILER: begin
                    if (adv) begin
                        bus.WR_EN   <= 1'b1;
                        bus.WR_DATA <= trl_word(wcnt[11:0]);
                        evt_cnt     <= evt_cnt + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_ch_readout.sv
// Bench for multi_ch_readout: random per-channel sample buffers, an event-level reference
// model of the expected FIFO word stream, and directed reset/stall/abort/wrap scenarios.
module tb_multi_ch_readout;

    localparam int NCH     = 4;
    localparam int CH_BITS = 2;
    localparam int NSAMP   = 4;
    localparam int DW      = 16;
    localparam int WPC     = 1 + NSAMP;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    multi_ch_readout_if #(.NCH(NCH), .CH_BITS(CH_BITS), .DW(DW)) bus ();

    multi_ch_readout #(.NCH(NCH), .CH_BITS(CH_BITS), .NSAMP(NSAMP), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [DW-1:0] data_tab [NCH][1024];
    logic [9:0]    src_ptr [NCH] = '{default: '0};
    int            rd_cnt  [NCH] = '{default: 0};
    logic [9:0]    mdl_ptr [NCH];
    int            rd_base [NCH];
    logic [15:0]   mdl_evt;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int cyc = 0, busy_cnt = 0, got_total = 0;
    int target, t0, lim, busy_base, cycles, g0;
    int n_checks = 0, n_pass = 0;

    // Channel buffers: the word at the read pointer of the selected channel.
    always_comb bus.CH_DATA = data_tab[bus.CHSEL][src_ptr[bus.CHSEL]];

    always @(posedge CLK) begin
        if (bus.CH_RD) begin
            src_ptr[bus.CHSEL] <= src_ptr[bus.CHSEL] + 10'd1;
            rd_cnt[bus.CHSEL]  <= rd_cnt[bus.CHSEL] + 1;
        end
    end

    always @(negedge CLK) begin
        cyc++;
        if (bus.BUSY) busy_cnt++;
        if (bus.WR_EN) begin
            got_q.push_back(bus.WR_DATA);
            got_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Expected word stream of one event with snapshot mask m.
    task automatic push_event(input logic [NCH-1:0] m);
        int k = 0;
        exp_q.push_back(16'hA000 | (16'(m) << 8) | 16'(mdl_evt[7:0]));
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                k++;
                exp_q.push_back(16'hC000 | 16'(c));
                for (int s = 0; s < NSAMP; s++) begin
                    exp_q.push_back(data_tab[c][mdl_ptr[c]]);
                    mdl_ptr[c] = mdl_ptr[c] + 10'd1;
                end
            end
        end
        exp_q.push_back(16'hE000 | 16'((1 + k * (1 + NSAMP)) & 12'hFFF));
        mdl_evt = mdl_evt + 16'd1;
    endtask

    task automatic launch(input logic [NCH-1:0] m, input int n);
        for (int i = 0; i < n; i++) push_event(m);
        target     = got_total + exp_q.size();
        lim        = 100 + 40 * exp_q.size();
        bus.DAVAIL = m;
        t0         = cyc;
        busy_base  = busy_cnt;
        rd_base    = rd_cnt;
    endtask

    task automatic finish(input bit toggle, input bit stall, output int ncyc);
        while (1) begin
            tick();
            if (got_total >= target) begin
                bus.DAVAIL    = '0;
                bus.FIFO_FULL = 1'b0;
                break;
            end
            if (cyc - t0 > lim) begin
                chk("timeout", got_total, target);
                bus.DAVAIL    = '0;
                bus.FIFO_FULL = 1'b0;
                break;
            end
            if (toggle) bus.DAVAIL = (got_total >= target - 1) ? '0 : 4'($urandom);
            if (stall)  bus.FIFO_FULL = ($urandom_range(0, 3) == 0);
        end
        ncyc = cyc - t0;
    endtask

    task automatic drain(input string tag);
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reads(input string tag, input logic [NCH-1:0] m);
        for (int c = 0; c < NCH; c++)
            chk(tag, rd_cnt[c] - rd_base[c], m[c] ? NSAMP : 0);
    endtask

    initial begin
        RST           = 1'b1;
        bus.DAVAIL    = 4'hF;
        bus.FIFO_FULL = 1'b0;
        mdl_evt       = '0;
        for (int c = 0; c < NCH; c++) begin
            mdl_ptr[c] = '0;
            for (int i = 0; i < 1024; i++) data_tab[c][i] = DW'($urandom);
        end

        // Reset held two cycles with all channels requesting.
        tick();
        tick();
        chk("rst_wr_en", bus.WR_EN, 0);
        chk("rst_wr_data", bus.WR_DATA, 0);
        chk("rst_ch_rd", bus.CH_RD, 0);
        chk("rst_chsel", bus.CHSEL, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_no_words", got_total, 0);

        // First event after reset release, all four channels.
        launch(4'hF, 1);
        RST = 1'b0;
        tick();
        chk("lat_c1_wr_en", bus.WR_EN, 0);
        chk("lat_c1_busy", bus.BUSY, 1);
        tick();
        chk("lat_c2_wr_en", bus.WR_EN, 1);
        chk("lat_c2_hdr", bus.WR_DATA, 16'hAF00);
        finish(0, 0, cycles);
        chk("all_ch_cycles", cycles, 3 + NCH * WPC);
        chk("all_ch_busy", busy_cnt - busy_base, 2 + NCH * WPC + 1);
        chk_reads("all_ch_reads", 4'hF);
        drain("all_ch_word");
        tick();
        chk("busy_drop", bus.BUSY, 0);

        // Two channels, no stall.
        launch(4'b0101, 1);
        finish(0, 0, cycles);
        chk("m5_cycles", cycles, 3 + 2 * WPC);
        chk_reads("m5_reads", 4'b0101);
        drain("m5_word");

        // Three-cycle backpressure in the middle of channel 1 readout.
        launch(4'b0010, 1);
        while (rd_cnt[1] - rd_base[1] < 2 && cyc - t0 < 50) tick();
        chk("stall_reached", rd_cnt[1] - rd_base[1], 2);
        g0 = rd_cnt[1];
        bus.FIFO_FULL = 1'b1;
        #1;
        chk("stall_ch_rd_0", bus.CH_RD, 0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk("stall_ch_rd", bus.CH_RD, 0);
            chk("stall_wr_en", bus.WR_EN, 0);
            chk("stall_chsel", bus.CHSEL, 1);
        end
        tick();
        chk("stall_wr_en_after", bus.WR_EN, 0);
        chk("stall_no_pop", rd_cnt[1], g0);
        bus.FIFO_FULL = 1'b0;
        #1;
        chk("stall_resume_rd", bus.CH_RD, 1);
        finish(0, 0, cycles);
        chk_reads("stall_reads", 4'b0010);
        drain("stall_word");

        // DAVAIL toggling mid-event must not disturb the snapshot mask.
        launch(4'b1001, 1);
        finish(1, 0, cycles);
        chk_reads("toggle_reads", 4'b1001);
        drain("toggle_word");

        // Random masks with random backpressure and DAVAIL noise.
        for (int e = 0; e < 20; e++) begin
            launch(4'($urandom_range(1, 15)), 1);
            finish(e[0], 1, cycles);
            drain("rand_word");
        end

        // Reset in the middle of READOUT: abort without trailer, event counter restarts.
        launch(4'b1010, 1);
        while (rd_cnt[1] - rd_base[1] < 2 && cyc - t0 < 50) tick();
        chk("abort_reached", rd_cnt[1] - rd_base[1], 2);
        RST        = 1'b1;
        bus.DAVAIL = '0;
        #1;
        chk("abort_ch_rd_now", bus.CH_RD, 0);
        tick();
        chk("abort_wr_en", bus.WR_EN, 0);
        chk("abort_ch_rd", bus.CH_RD, 0);
        chk("abort_busy", bus.BUSY, 0);
        RST = 1'b0;
        g0  = got_total;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_trailer", got_total, g0);
        chk("abort_hdr", got_q.size() > 0 ? 32'(got_q[0]) : 32'hDEAD, exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hBEEF);
        got_q.delete();
        exp_q.delete();
        mdl_evt = '0;
        mdl_ptr = src_ptr;
        launch(4'b0001, 1);
        chk("abort_next_evt0", exp_q[0], 16'hA100);
        finish(0, 0, cycles);
        drain("post_abort_word");

        // Back-to-back events; header event field wraps FF -> 00.
        launch(4'b0001, 260);
        finish(0, 0, cycles);
        chk("b2b_cycles", cycles, 260 * (3 + WPC));
        chk("b2b_evt_model", mdl_evt, 261);
        drain("b2b_word");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
